// File: rtl/incr_arbiter.sv
// Round-robin sequencer that shares one combinational +1 incrementer between NREQ requesters.
// It grants one request per transaction, registers the result and acks the winner for one cycle.
module incr_arbiter #(
    parameter int WIDTH = 8,
    parameter int NREQ  = 3
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] din,
    input  logic                  stall,
    output logic [WIDTH-1:0]      inc_a,
    input  logic [WIDTH-1:0]      inc_y,
    output logic [NREQ-1:0]       ack,
    output logic [WIDTH-1:0]      result,
    output logic                  result_wrap,
    output logic [1:0]            grant_id,
    output logic                  busy
);

    typedef enum logic {
        ST_IDLE,
        ST_BUSY
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [1:0]        r_last;
    logic [1:0]        r_grant;
    logic [NREQ-1:0]   r_ack;
    logic [WIDTH-1:0]  r_result;
    logic              r_wrap;

    logic [1:0]        w_pick;
    logic [1:0]        w_idx;
    logic [WIDTH-1:0]  w_sel_op;
    logic [NREQ-1:0]   w_onehot;
    logic              w_grant_live;
    logic              w_start;
    logic              w_complete;

    // Walk downwards so the candidate closest after r_last is written last and wins.
    always_comb begin
        w_pick = '0;
        w_idx  = '0;
        for (int k = NREQ; k >= 1; k--) begin
            w_idx = 2'((int'(r_last) + k) % NREQ);
            if (req[w_idx]) begin
                w_pick = w_idx;
            end
        end
    end

    assign w_sel_op     = din[int'(r_grant)*WIDTH +: WIDTH];
    assign w_grant_live = req[r_grant];
    assign w_onehot     = {{(NREQ-1){1'b0}}, 1'b1} << r_grant;

    always_comb begin
        w_state_next = r_state;
        w_start      = 1'b0;
        w_complete   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (|req) begin
                    w_start      = 1'b1;
                    w_state_next = ST_BUSY;
                end
            end
            ST_BUSY: begin
                // A withdrawn request aborts even if the datapath is stalled.
                if (!w_grant_live) begin
                    w_state_next = ST_IDLE;
                end else if (!stall) begin
                    w_complete   = 1'b1;
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state  <= ST_IDLE;
            r_last   <= 2'(NREQ - 1);
            r_grant  <= '0;
            r_ack    <= '0;
            r_result <= '0;
            r_wrap   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_ack   <= '0;
            if (w_start) begin
                r_grant <= w_pick;
            end
            if (w_complete) begin
                r_result <= inc_y;
                r_wrap   <= (w_sel_op == {WIDTH{1'b1}});
                r_ack    <= w_onehot;
                r_last   <= r_grant;
            end
        end
    end

    // The incrementer sees zero whenever no transaction is in flight.
    assign inc_a       = (r_state == ST_BUSY) ? w_sel_op : '0;
    assign ack         = r_ack;
    assign result      = r_result;
    assign result_wrap = r_wrap;
    assign grant_id    = r_grant;
    assign busy        = (r_state == ST_BUSY);

endmodule

// File: tb/tb_incr_arbiter.sv
// Directed bench for incr_arbiter: reset, single grant, round robin, wrap, stall/withdraw, reset mid-op.
module tb_incr_arbiter;

    logic        clock;
    logic        reset;
    logic [2:0]  req;
    logic [23:0] din;
    logic        stall;
    logic [7:0]  inc_a;
    logic [7:0]  inc_y;
    logic [2:0]  ack;
    logic [7:0]  result;
    logic        result_wrap;
    logic [1:0]  grant_id;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    incr_arbiter #(.WIDTH(8), .NREQ(3)) dut (
        .clock(clock), .reset(reset), .req(req), .din(din), .stall(stall),
        .inc_a(inc_a), .inc_y(inc_y), .ack(ack), .result(result),
        .result_wrap(result_wrap), .grant_id(grant_id), .busy(busy)
    );

    // External shared incrementer
    assign inc_y = inc_a + 8'd1;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0; req = 3'b111; stall = 1'b0;
        din = {8'h30, 8'h20, 8'h10};
        for (int c = 0; c < 3; c++) begin
            tick();
            n_checks++; if (ack !== 3'b000) begin n_fail++; $display("FAIL reset_ack cyc%0d got %b exp 000", c, ack); end
            n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy cyc%0d got %b exp 0", c, busy); end
            n_checks++; if (result !== 8'h00) begin n_fail++; $display("FAIL reset_result cyc%0d got %h exp 00", c, result); end
            n_checks++; if (inc_a !== 8'h00) begin n_fail++; $display("FAIL reset_inc_a cyc%0d got %h exp 00", c, inc_a); end
            n_checks++; if (grant_id !== 2'd0) begin n_fail++; $display("FAIL reset_grant cyc%0d got %0d exp 0", c, grant_id); end
        end
        req = 3'b000;
        reset = 1'b1;
        tick();
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_after_reset busy got %b exp 0", busy); end
    endtask

    task automatic test_single();
        din = {8'h00, 8'h41, 8'h00};
        req = 3'b010;
        tick();
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy got %b exp 1", busy); end
        n_checks++; if (grant_id !== 2'd1) begin n_fail++; $display("FAIL single_grant got %0d exp 1", grant_id); end
        n_checks++; if (inc_a !== 8'h41) begin n_fail++; $display("FAIL single_inc_a got %h exp 41", inc_a); end
        n_checks++; if (ack !== 3'b000) begin n_fail++; $display("FAIL single_early_ack got %b exp 000", ack); end
        tick();
        n_checks++; if (ack !== 3'b010) begin n_fail++; $display("FAIL single_ack got %b exp 010", ack); end
        n_checks++; if (result !== 8'h42) begin n_fail++; $display("FAIL single_result got %h exp 42", result); end
        n_checks++; if (result_wrap !== 1'b0) begin n_fail++; $display("FAIL single_wrap got %b exp 0", result_wrap); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_low got %b exp 0", busy); end
        req = 3'b000;
        tick();
        n_checks++; if (ack !== 3'b000) begin n_fail++; $display("FAIL single_ack_pulse got %b exp 000", ack); end
        n_checks++; if (inc_a !== 8'h00) begin n_fail++; $display("FAIL single_idle_inc_a got %h exp 00", inc_a); end
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_id  [4];
        logic [2:0] exp_ack [4];
        logic [7:0] exp_res [4];
        exp_id  = '{2'd0, 2'd1, 2'd2, 2'd0};
        exp_ack = '{3'b001, 3'b010, 3'b100, 3'b001};
        exp_res = '{8'h11, 8'h21, 8'h31, 8'h11};
        do_reset();
        din = {8'h30, 8'h20, 8'h10};
        req = 3'b111;
        for (int t = 0; t < 4; t++) begin
            tick();
            n_checks++; if (grant_id !== exp_id[t]) begin n_fail++; $display("FAIL rr_grant t%0d got %0d exp %0d", t, grant_id, exp_id[t]); end
            n_checks++; if (ack !== 3'b000) begin n_fail++; $display("FAIL rr_noack t%0d got %b exp 000", t, ack); end
            tick();
            n_checks++; if (ack !== exp_ack[t]) begin n_fail++; $display("FAIL rr_ack t%0d got %b exp %b", t, ack, exp_ack[t]); end
            n_checks++; if (result !== exp_res[t]) begin n_fail++; $display("FAIL rr_result t%0d got %h exp %h", t, result, exp_res[t]); end
        end
        req = 3'b000;
        tick();
    endtask

    task automatic test_wrap();
        din = {8'h00, 8'h00, 8'hFF};
        req = 3'b001;
        tick();
        tick();
        n_checks++; if (ack !== 3'b001) begin n_fail++; $display("FAIL wrap_ack got %b exp 001", ack); end
        n_checks++; if (result !== 8'h00) begin n_fail++; $display("FAIL wrap_result got %h exp 00", result); end
        n_checks++; if (result_wrap !== 1'b1) begin n_fail++; $display("FAIL wrap_flag got %b exp 1", result_wrap); end
        req = 3'b000;
        tick();
        n_checks++; if (result !== 8'h00 || result_wrap !== 1'b1) begin n_fail++; $display("FAIL wrap_hold got %h/%b exp 00/1", result, result_wrap); end
    endtask

    task automatic test_stall_withdraw();
        din = {8'h7E, 8'h00, 8'h05};
        req = 3'b100;
        stall = 1'b1;
        tick();
        n_checks++; if (grant_id !== 2'd2) begin n_fail++; $display("FAIL stall_grant got %0d exp 2", grant_id); end
        for (int c = 0; c < 4; c++) begin
            tick();
            n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL stall_busy cyc%0d got %b exp 1", c, busy); end
            n_checks++; if (ack !== 3'b000) begin n_fail++; $display("FAIL stall_ack cyc%0d got %b exp 000", c, ack); end
            n_checks++; if (inc_a !== 8'h7E) begin n_fail++; $display("FAIL stall_inc_a cyc%0d got %h exp 7e", c, inc_a); end
        end
        stall = 1'b0;
        tick();
        n_checks++; if (ack !== 3'b100) begin n_fail++; $display("FAIL release_ack got %b exp 100", ack); end
        n_checks++; if (result !== 8'h7F) begin n_fail++; $display("FAIL release_result got %h exp 7f", result); end
        req = 3'b001;
        tick();
        n_checks++; if (grant_id !== 2'd0 || busy !== 1'b1) begin n_fail++; $display("FAIL wd_grant got %0d/%b exp 0/1", grant_id, busy); end
        req = 3'b000;
        tick();
        n_checks++; if (ack !== 3'b000) begin n_fail++; $display("FAIL wd_ack got %b exp 000", ack); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL wd_busy got %b exp 0", busy); end
        n_checks++; if (result !== 8'h7F) begin n_fail++; $display("FAIL wd_result_hold got %h exp 7f", result); end
        // Pointer still at 2, so requester 0 beats requester 1.
        req = 3'b011;
        tick();
        n_checks++; if (grant_id !== 2'd0) begin n_fail++; $display("FAIL wd_pointer got %0d exp 0", grant_id); end
        tick();
        n_checks++; if (ack !== 3'b001) begin n_fail++; $display("FAIL wd_next_ack got %b exp 001", ack); end
        n_checks++; if (result !== 8'h06) begin n_fail++; $display("FAIL wd_next_result got %h exp 06", result); end
        req = 3'b000;
        tick();
    endtask

    task automatic test_reset_mid_op();
        din = {8'h00, 8'h41, 8'h05};
        req = 3'b010;
        tick();
        n_checks++; if (busy !== 1'b1 || grant_id !== 2'd1) begin n_fail++; $display("FAIL mid_grant got %0d/%b exp 1/1", grant_id, busy); end
        reset = 1'b0;
        tick();
        n_checks++; if (ack !== 3'b000) begin n_fail++; $display("FAIL mid_ack got %b exp 000", ack); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_busy got %b exp 0", busy); end
        n_checks++; if (result !== 8'h00) begin n_fail++; $display("FAIL mid_result got %h exp 00", result); end
        reset = 1'b1;
        req = 3'b011;
        tick();
        n_checks++; if (grant_id !== 2'd0) begin n_fail++; $display("FAIL mid_regrant got %0d exp 0", grant_id); end
        tick();
        n_checks++; if (ack !== 3'b001) begin n_fail++; $display("FAIL mid_ack2 got %b exp 001", ack); end
        n_checks++; if (result !== 8'h06) begin n_fail++; $display("FAIL mid_result2 got %h exp 06", result); end
        req = 3'b000;
        tick();
    endtask

    initial begin
        reset = 1'b0; req = '0; din = '0; stall = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_wrap();
        test_stall_withdraw();
        test_reset_mid_op();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
